// File: rtl/temp_conv_seq.sv
// temp_conv_seq: multi-cycle signed fixed-point C<->F converter with a restoring divider
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_mode/in_temp operand handshake
// (in_mode 0 = C->F, 1 = F->C); out_valid/out_ready/out_temp/out_mode sticky result handshake;
// busy is high outside IDLE.
// Define TEMP_CONV_ROUND_EN to round to nearest (ties away from zero) instead of truncating.
module temp_conv_seq #(
  parameter int W    = 16,
  parameter int FRAC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic signed [W-1:0] in_temp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+1:0] out_temp,
  output logic                out_mode,
  output logic                busy
);
  localparam int N  = W + 4;
  localparam int CW = $clog2(N);
  localparam logic signed [N:0] K = (N+1)'(32 << FRAC);
  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;
  state_t                r_state, w_next;
  logic                  r_mode, r_neg, r_out_valid, r_out_mode;
  logic signed [W-1:0]   r_temp;
  logic        [N-1:0]   r_q;
  logic        [3:0]     r_rem, r_div;
  logic        [CW-1:0]  r_cnt;
  logic signed [W+1:0]   r_out_temp;
  logic signed [N:0]     w_ext, w_sub, w_num;
  logic        [N-1:0]   w_mag;
  logic        [4:0]     w_sh;
  logic                  w_ge;
  logic        [3:0]     w_diff;
  logic        [N:0]     w_qmag;
  logic signed [W+1:0]   w_res;
  assign w_ext  = {{(N+1-W){r_temp[W-1]}}, r_temp};
  assign w_sub  = w_ext - K;
  // x*5 and x*9 as shift-add so the N+1-bit width is kept throughout
  assign w_num  = r_mode ? (w_sub <<< 2) + w_sub : (w_ext <<< 3) + w_ext;
  assign w_mag  = w_num[N] ? N'(-w_num) : w_num[N-1:0];
  assign w_sh   = {r_rem, r_q[N-1]};
  assign w_ge   = w_sh >= {1'b0, r_div};
  // remainder after subtract is below the divisor, so 4 bits of the difference suffice
  assign w_diff = w_sh[3:0] - r_div;
`ifdef TEMP_CONV_ROUND_EN
  assign w_qmag = {1'b0, r_q} + (N+1)'({r_rem, 1'b0} >= {1'b0, r_div});
`else
  assign w_qmag = {1'b0, r_q};
`endif
  assign w_res  = (W+2)'((r_neg ? -$signed(w_qmag) : $signed(w_qmag)) + (r_mode ? '0 : K));
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign out_valid = r_out_valid;
  assign out_temp  = r_out_temp;
  assign out_mode  = r_out_mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (in_valid ? PREP : IDLE) :
             r_state == PREP ? DIV :
             r_state == DIV  ? (r_cnt == CW'(N-1) ? FIX : DIV) :
             r_state == FIX  ? DONE :
             (r_out_valid && out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_temp      <= '0;
      r_neg       <= 1'b0;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_out_temp  <= '0;
      r_out_mode  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_mode <= in_mode;
        r_temp <= in_temp;
      end
    end else if (r_state == PREP) begin
      r_neg <= w_num[N];
      r_q   <= w_mag;
      r_rem <= '0;
      r_div <= r_mode ? 4'd9 : 4'd5;
      r_cnt <= '0;
    end else if (r_state == DIV) begin
      r_q   <= {r_q[N-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_sh[3:0];
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == FIX) begin
      r_out_temp  <= w_res;
      r_out_mode  <= r_mode;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_temp_conv_seq.sv
// tb_temp_conv_seq: directed and scoreboard checks of temp_conv_seq (W=16, FRAC=4)
module tb_temp_conv_seq;
  localparam int W = 16;
  localparam int K = 32 << 4;
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_mode = 1'b0;
  logic signed [W-1:0] in_temp = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W+1:0] out_temp;
  logic                out_mode;
  logic                busy;
  int                  n_chk = 0;
  int                  n_err = 0;
  int                  sb[$];
  logic signed [31:0]  got;
  bit                  seen;
  temp_conv_seq #(.W(W), .FRAC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_temp(in_temp), .out_valid(out_valid),
    .out_ready(out_ready), .out_temp(out_temp), .out_mode(out_mode), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int model(input bit m, input int t);
    int num, d, mag, q, r;
    num = m ? (t - K) * 5 : t * 9;
    d   = m ? 9 : 5;
    mag = num < 0 ? -num : num;
    q   = mag / d;
    r   = mag % d;
`ifdef TEMP_CONV_ROUND_EN
    if (2 * r >= d) q++;
`endif
    q = num < 0 ? -q : q;
    return m ? q : q + K;
  endfunction
  task automatic run(input bit m, input logic signed [W-1:0] t, input int hold, output logic signed [31:0] res);
    int cyc;
    logic signed [31:0] exp, snap;
    sb.push_back(model(m, int'(t)));
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_mode = m; in_temp = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, 22);
    exp = sb.size() != 0 ? sb.pop_front() : 'x;
    res = out_temp;
    chk("out_temp_model", out_temp, exp);
    chk("out_mode", out_mode, m);
    snap = out_temp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_temp", out_temp, snap);
      chk("hold_in_ready", in_ready, 0);
      if (i == 20) begin in_valid = 1'b1; in_mode = ~m; in_temp = 16'sd100; end
      if (i == 23) in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_temp", out_temp, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_busy", busy, 0);
    #24 rst_n = 1'b1;
`ifdef TEMP_CONV_ROUND_EN
    run(1'b0, 16'sd592, 0, got);  chk("c2f_37", got, 1578);
    run(1'b0, -16'sd16, 0, got);  chk("c2f_m1", got, 483);
`else
    run(1'b0, 16'sd592, 0, got);  chk("c2f_37", got, 1577);
    run(1'b0, -16'sd16, 0, got);  chk("c2f_m1", got, 484);
`endif
    run(1'b1, 16'sd3392, 0, got); chk("f2c_212", got, 1600);
    run(1'b0, -16'sd640, 0, got); chk("c2f_m40", got, -640);
    run(1'b1, 16'sd512, 0, got);  chk("f2c_zero", got, 0);
    run(1'b1, -16'sd32768, 0, got);
    run(1'b0, -16'sd32768, 0, got);
    run(1'b0, 16'sd32767, 0, got);
    for (int i = 0; i < 6; i++) run(1'($urandom_range(1)), W'($urandom), 0, got);
    run(1'b0, 16'sd160, 50, got); chk("c2f_10", got, 800);
    repeat (30) @(negedge clk);
    chk("no_second_accept_valid", out_valid, 0);
    chk("no_second_accept_busy", busy, 0);
    @(negedge clk);
    in_mode = 1'b0; in_temp = 16'sd592; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_temp", out_temp, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) @(negedge clk) if (out_valid) seen = 1'b1;
    chk("midrst_no_emit", seen, 0);
    run(1'b0, 16'sd0, 0, got); chk("c2f_zero_after_rst", got, 512);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/temp_conv_seq.md
Name: temp_conv_seq

Overview:
- Parametrised, multi-cycle signed fixed-point temperature converter; successor to the combinational Celsius-to-Fahrenheit converter.
- Supports both directions: Celsius to Fahrenheit (C->F) and Fahrenheit to Celsius (F->C).
- Takes operands through a valid/ready input handshake and computes the /5 or /9 with an iterative restoring divider.
- Holds each result under a valid/ready output handshake until consumed; sits between sensor/ALU front-end logic and the FPU result path.

Parameters:
- W, 16, input width (signed two's complement); legal W >= 8.
- FRAC, 4, fractional bits of input and output; legal 0 <= FRAC <= W-7.
- N (localparam), W+4, numerator magnitude width = divider iteration count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_mode  in  1  0 = C->F, 1 = F->C; sampled at accept.
- in_temp  in  W  signed input temperature, FRAC fractional bits.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_temp  out  W+2  signed result, FRAC fractional bits.
- out_mode  out  1  mode of the operation that produced out_temp.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync to clk on release): state=IDLE, in_ready=1, out_valid=0, out_temp=0, out_mode=0, busy=0, divider regs=0.
- Arithmetic, K = 32<<FRAC:
  - C->F: out = Q(in*9, 5) + K.
  - F->C: out = Q((in-K)*5, 9).
  - Q(a,d) divides |a| by d via the restoring divider, then re-applies sign(a): truncation toward zero. Round mode is described under Optional Feature.
  - Intermediates are sign-extended to N+1 bits; results always fit W+2 bits, no saturation needed.
- FSM states: IDLE, PREP, DIV, FIX, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch mode/operand -> PREP.
  - PREP: form signed numerator, record sign, load magnitude and divisor (5 or 9), clear remainder -> DIV.
  - DIV: one shift/subtract per cycle, iteration counter 0..N-1. After iteration N-1 -> FIX.
  - FIX: apply sign and C->F offset; register out_temp and out_mode; out_valid<=1 -> DONE.
  - DONE: hold out_temp, out_mode and out_valid stable. On out_valid&&out_ready, out_valid<=0 -> IDLE.
- Latency: handshake at edge k gives out_valid high after edge k+N+2 (W+6 cycles; 22 for W=16). Latency is independent of data and mode.
- in_ready=0 in every state except IDLE; in_valid is ignored then, with no queuing.
- Output is sticky: out_valid stays high indefinitely until out_ready; values must not change while waiting.
- in_ready rises the cycle after the output handshake, so the next accept is at the earliest one cycle after out_ready.
- Reset mid-operation: immediate return to reset values; the partial result is discarded and never emitted.
- in_temp = most negative value (-2^(W-1)): magnitude is handled in N bits, so the result must be correct (no overflow).
- Zero numerator gives exactly 0 (+K for C->F). Sign is never negative-zero-affected.

Optional Feature:
- Macro TEMP_CONV_ROUND_EN.
- Defined: Q rounds to nearest, ties away from zero. After DIV, if 2*remainder >= divisor, the magnitude quotient is incremented in FIX, before the sign is applied. Latency is unchanged.
- Undefined: truncation toward zero; no rounding logic is synthesised.

Test Plan:
- W=16, FRAC=4. C->F of 37.0 (in=592):
  - Without TEMP_CONV_ROUND_EN: out_temp=1577 (98.5625).
  - With TEMP_CONV_ROUND_EN: out_temp=1578.
  - out_valid rises exactly 22 cycles after the accept edge.
- F->C of 212.0 (in=3392) -> out_temp=1600 (100.0). C->F of -40.0 (in=-640) -> out_temp=-640.
- C->F of -1.0 (in=-16):
  - Truncate: out_temp=484.
  - Round: out_temp=483.
- Hold out_ready=0 for 50 cycles after out_valid:
  - out_valid and out_temp stay stable, in_ready stays 0, and a second in_valid pulse is not accepted.
  - Release out_ready: one handshake, then in_ready=1 the next cycle.
- Assert rst_n=0 at cycle 10 of DIV:
  - All outputs go to reset values asynchronously, and no out_valid pulse appears after release.
  - A following conversion of 0.0 C->F gives 512.
- F->C of in=-32768 -> out_temp = trunc((-32768-512)*5/9) = -18488; the bench checks this against a golden model.
